imem_arbiter: RTL
=================

# imem_arbiter

Shares the single-ported instruction/data memory between the Fetch stage (instruction reads) and the load/store unit (data reads and writes). It accepts one request at a time and keeps exactly one transaction outstanding. Grant priority goes to the LSU, with anti-starvation for fetch. Responses return to the owning requester, and a fetch flush discards the in-flight fetch response.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive contended LSU wins before fetch is forced to win (1..15)
- TIMEOUT, 255, max cycles in ISSUE+WAIT before abort (1..255)

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- i_if_req  in  1  fetch request; held until o_if_gnt
- i_if_addr  in  ADDR_W  fetch address; word aligned
- i_if_flush  in  1  fetch flush; kills the pending fetch response
- o_if_gnt  out  1  fetch request accepted (1-cycle pulse)
- o_if_rvld  out  1  fetch read data valid (1-cycle pulse)
- o_if_rdata  out  DATA_W  fetch read data
- i_ls_req  in  1  LSU request; held until o_ls_gnt
- i_ls_we  in  1  1 = write, 0 = read
- i_ls_addr  in  ADDR_W  LSU address
- i_ls_wdata  in  DATA_W  write data
- i_ls_be  in  DATA_W/8  byte enables
- o_ls_gnt  out  1  LSU request accepted (1-cycle pulse)
- o_ls_rvld  out  1  LSU response (read data or write ack)
- o_ls_rdata  out  DATA_W  LSU read data
- o_mem_req  out  1  memory request
- o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be  out  1/ADDR_W/DATA_W/DATA_W/8  latched request fields
- i_mem_gnt  in  1  memory accepted request
- i_mem_rvld  in  1  memory response valid (reads and writes)
- i_mem_rdata  in  DATA_W  memory read data
- o_bus_err  out  1  timeout abort (1-cycle pulse)

## Operation
States: IDLE, ISSUE, WAIT.

- **IDLE, arbitration**
  - Only i_ls_req set -> LSU wins.
  - Only i_if_req set, and i_if_flush=0 -> fetch wins. If i_if_flush=1, the fetch request is ignored this cycle.
  - Both set -> LSU wins unless starve_cnt == STARVE_MAX, in which case fetch wins.
  - The winner's gnt pulses this cycle. Owner, fields, drop=0 and tmo_cnt=0 are registered. Next state is ISSUE.
- **starve_cnt** (4-bit)
  - +1 on each contended LSU win, saturating at STARVE_MAX.
  - Cleared on any fetch grant.
- **ISSUE**
  - o_mem_req=1 with the latched fields held stable.
  - i_mem_gnt=1 -> WAIT.
  - For fetch transactions, o_mem_we=0 and o_mem_be is all ones.
- **WAIT**
  - o_mem_req=0.
  - i_mem_rvld=1 -> route the response to the owner, then go to IDLE.
  - Routing is combinational and same cycle: o_x_rvld = i_mem_rvld, o_x_rdata = i_mem_rdata.
  - The other requester's rvld stays 0 and its rdata is 0.
- **Flush**
  - i_if_flush=1 while owner=fetch in ISSUE or WAIT sets drop=1.
  - The transaction still completes on the memory side.
  - With drop=1 (or flush on the response cycle itself), o_if_rvld is suppressed.
  - An LSU-owned transaction is unaffected by flush.
- **Timeout**
  - tmo_cnt increments each cycle in ISSUE or WAIT.
  - On reaching TIMEOUT: o_bus_err pulses, and the owner gets rvld=1 with rdata=0 (fetch still honours drop). Next state is IDLE.
  - A late i_mem_rvld arriving in IDLE is ignored.
- **Reset** (also mid-transaction): state=IDLE, owner, drop, starve_cnt and tmo_cnt cleared, all outputs 0. A transaction aborted by reset produces no response.

## Timing
- Minimum transaction is 3 cycles: gnt in IDLE (T), mem_req in T+1 (gnt same cycle), rvld in T+2 at the earliest.
- The next grant comes at T+3 at the earliest. Back-to-back throughput is one transaction per 3 cycles.
- gnt is combinational from IDLE and the request inputs. All other control is registered state.
- The memory must not assert i_mem_rvld in the same cycle as i_mem_gnt.
- Address and data are captured only at grant; requester changes after gnt have no effect.
- Reset values: o_if_gnt, o_if_rvld, o_ls_gnt, o_ls_rvld, o_mem_req, o_mem_we, o_bus_err = 0; all data and address outputs = 0.

## Test plan
- **Single fetch:** i_if_req, addr 0x0000_0010; memory gnt immediately, rvld 1 cycle later with 0x0000_0013 -> o_if_gnt at T, o_mem_addr=0x10 at T+1, o_if_rvld with rdata 0x13 at T+2, o_ls_rvld=0.
- **LSU write vs fetch contention:** both request, LSU we=1 addr 0x100 wdata 0xDEADBEEF be=0xF -> LSU granted first, o_mem_we=1 with those fields. Fetch is granted after the LSU response.
- **Starvation:** LSU and fetch both request continuously, STARVE_MAX=4 -> 4 LSU grants, then a fetch grant, then starve_cnt=0 and the LSU resumes winning.
- **Flush in WAIT:** fetch in WAIT, i_if_flush pulsed, rvld 0xAAAA_AAAA 2 cycles later -> o_if_rvld stays 0, state returns to IDLE, and a following LSU read completes normally.
- **Timeout:** TIMEOUT=8, memory never asserts gnt -> o_bus_err pulses in the 8th cycle after ISSUE entry, owner rvld=1 with rdata=0, then IDLE.
- **Reset mid-WAIT:** rst asserted during an LSU read -> next cycle all outputs are 0 and state is IDLE. A late i_mem_rvld produces no o_ls_rvld.

Source files
------------

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one single-ported memory between instruction fetch and the LSU.
// One transaction in flight at a time; LSU has priority, with a starvation override for fetch.
module imem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_if_req,
    input  logic [ADDR_W-1:0]   i_if_addr,
    input  logic                i_if_flush,
    output logic                o_if_gnt,
    output logic                o_if_rvld,
    output logic [DATA_W-1:0]   o_if_rdata,
    input  logic                i_ls_req,
    input  logic                i_ls_we,
    input  logic [ADDR_W-1:0]   i_ls_addr,
    input  logic [DATA_W-1:0]   i_ls_wdata,
    input  logic [DATA_W/8-1:0] i_ls_be,
    output logic                o_ls_gnt,
    output logic                o_ls_rvld,
    output logic [DATA_W-1:0]   o_ls_rdata,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_be,
    input  logic                i_mem_gnt,
    input  logic                i_mem_rvld,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    output logic                o_bus_err
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t                r_state;
    logic                  r_owner_ls;
    logic                  r_drop;
    logic [3:0]            r_starve;
    logic [7:0]            r_tmo;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic [DATA_W-1:0]     r_mem_wdata;
    logic [DATA_W/8-1:0]   r_mem_be;

    logic w_idle;
    logic w_busy;
    logic w_if_eff;
    logic w_contend;
    logic w_ls_win;
    logic w_if_win;
    logic w_resp;
    logic w_tmo_hit;
    logic w_done;
    logic w_if_rvld;
    logic w_ls_rvld;

    // A flushed fetch request is invisible to arbitration in that cycle.
    assign w_idle    = (r_state == S_IDLE) && !rst;
    assign w_busy    = (r_state != S_IDLE) && !rst;
    assign w_if_eff  = i_if_req && !i_if_flush;
    assign w_contend = i_ls_req && w_if_eff;
    assign w_ls_win  = w_idle && i_ls_req && !(w_if_eff && (r_starve == STARVE_LIM));
    assign w_if_win  = w_idle && w_if_eff && !w_ls_win;

    // A real response in the last allowed cycle beats the timeout.
    assign w_resp    = (r_state == S_WAIT) && i_mem_rvld && !rst;
    assign w_tmo_hit = w_busy && !w_resp && (r_tmo == TMO_LAST);
    assign w_done    = w_resp || w_tmo_hit;
    assign w_if_rvld = w_done && !r_owner_ls && !r_drop && !i_if_flush;
    assign w_ls_rvld = w_done && r_owner_ls;

    assign o_if_gnt    = w_if_win;
    assign o_ls_gnt    = w_ls_win;
    assign o_if_rvld   = w_if_rvld;
    assign o_ls_rvld   = w_ls_rvld;
    assign o_if_rdata  = (w_if_rvld && w_resp) ? i_mem_rdata : '0;
    assign o_ls_rdata  = (w_ls_rvld && w_resp) ? i_mem_rdata : '0;
    assign o_bus_err   = w_tmo_hit;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_be    = r_mem_be;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_owner_ls  <= 1'b0;
            r_drop      <= 1'b0;
            r_starve    <= '0;
            r_tmo       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_ls_win || w_if_win) begin
                        r_state    <= S_ISSUE;
                        r_mem_req  <= 1'b1;
                        r_owner_ls <= w_ls_win;
                        r_drop     <= 1'b0;
                        r_tmo      <= '0;
                    end
                    if (w_ls_win) begin
                        r_mem_we    <= i_ls_we;
                        r_mem_addr  <= i_ls_addr;
                        r_mem_wdata <= i_ls_wdata;
                        r_mem_be    <= i_ls_be;
                        if (w_contend && (r_starve != STARVE_LIM)) begin
                            r_starve <= r_starve + 4'd1;
                        end
                    end else if (w_if_win) begin
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= i_if_addr;
                        r_mem_wdata <= '0;
                        r_mem_be    <= '1;
                        r_starve    <= '0;
                    end
                end
                S_ISSUE: begin
                    if (w_tmo_hit) begin
                        r_state   <= S_IDLE;
                        r_mem_req <= 1'b0;
                    end else begin
                        r_tmo <= r_tmo + 8'd1;
                        if (i_mem_gnt) begin
                            r_state   <= S_WAIT;
                            r_mem_req <= 1'b0;
                        end
                    end
                    if (i_if_flush && !r_owner_ls) begin
                        r_drop <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (w_done) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 8'd1;
                    end
                    if (i_if_flush && !r_owner_ls) begin
                        r_drop <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
